bus_xfer_ctrl: RTL and testbench

Command-driven sequencer for the shared 8-bit tri-state register bus (external data driver plus registers R1–R3). It queues transfer commands (load, move, swap) and turns each into one-hot bus-driver enables and register load strobes, with one two-cycle DRIVE/LATCH transfer per bus step. It sits between the command source and the bus structure, replacing hand-sequenced function codes. Under every condition, at most one driver is enabled on the bus.

---
 rtl/bus_xfer_pkg.sv | 64 ++++++
 rtl/cmd_fifo.sv | 65 ++++++
 rtl/bus_xfer_ctrl.sv | 153 +++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared types and helpers for the tri-state register bus sequencer.
// Driver index 0 is the external data driver; 1..3 are the registers R1..R3.
package bus_xfer_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_MOVE = 2'd2,
        OP_SWAP = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam logic [1:0] DRV_DATA = 2'd0;
    localparam logic [1:0] DRV_R1   = 2'd1;
    localparam logic [1:0] DRV_R2   = 2'd2;
    localparam logic [1:0] DRV_R3   = 2'd3;

    localparam logic [1:0] SWAP_LAST_STEP = 2'd2;

    typedef struct packed {
        op_e        op;
        logic [1:0] src;
        logic [1:0] dst;
    } cmd_hdr_t;

    localparam int HDR_W = $bits(cmd_hdr_t);

    function automatic logic cmd_legal(input cmd_hdr_t c);
        case (c.op)
            OP_LOAD:          return c.dst != DRV_DATA;
            OP_MOVE, OP_SWAP: return (c.src != DRV_DATA) && (c.dst != DRV_DATA) && (c.src != c.dst);
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] last_step(input op_e op);
        return (op == OP_SWAP) ? SWAP_LAST_STEP : 2'd0;
    endfunction

    // Returns {source driver, destination register} for one bus step.
    // The SWAP scratch register is whichever index a and b leave unused.
    function automatic logic [3:0] step_route(input cmd_hdr_t c, input logic [1:0] step);
        logic [1:0] spare;
        spare = 2'(int'(DRV_R1) + int'(DRV_R2) + int'(DRV_R3) - int'(c.src) - int'(c.dst));
        case (c.op)
            OP_LOAD: return {DRV_DATA, c.dst};
            OP_MOVE: return {c.src, c.dst};
            OP_SWAP: begin
                case (step)
                    2'd0:    return {c.src, spare};
                    2'd1:    return {c.dst, c.src};
                    default: return {spare, c.dst};
                endcase
            end
            default: return {DRV_DATA, DRV_DATA};
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; head is read combinationally, pointers wrap modulo DEPTH.
// A push and a pop on the same edge are allowed even when full.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                    Clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Command-driven sequencer for the shared tri-state register bus: queues LOAD/MOVE/SWAP
// commands and emits one-hot driver enables and load strobes, two cycles per bus step.
//
// state | meaning
// IDLE  | no transfer; pops and decodes the FIFO head when one is present
// DRIVE | source driver enabled, no load strobe
// LATCH | source still driven, destination strobed; last step pops the next command
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          Clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_src,
    input  logic [1:0]    cmd_dst,
    input  logic [DW-1:0] cmd_data,
    output logic [DW-1:0] data_out,
    output logic [3:0]    drv_en,
    output logic [2:0]    ld_en,
    output logic          busy,
    output logic          err
);
    localparam int CW = HDR_W + DW;
    localparam int NW = $clog2(DEPTH) + 1;

    logic [CW-1:0] fifo_din, fifo_dout;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [NW-1:0] fifo_count;
    cmd_hdr_t      head_hdr;
    logic [DW-1:0] head_data;

    state_e        state_q, state_d;
    logic [1:0]    step_q, step_d;
    cmd_hdr_t      cur_q, cur_d;
    logic [DW-1:0] cur_data_q, cur_data_d;
    logic [3:0]    drv_en_q, drv_en_d;
    logic [2:0]    ld_en_q, ld_en_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          err_q, err_d;
    logic          take;
    logic [3:0]    route;

    assign fifo_din  = {cmd_op, cmd_src, cmd_dst, cmd_data};
    assign head_hdr  = cmd_hdr_t'(fifo_dout[CW-1:DW]);
    assign head_data = fifo_dout[DW-1:0];
    assign cmd_ready = !fifo_full || fifo_pop;
    assign fifo_push = cmd_valid && cmd_ready;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_cmd_fifo (
        .Clock (Clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cur_d      = cur_q;
        cur_data_d = cur_data_q;
        err_d      = 1'b0;
        take       = 1'b0;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE:  take = !fifo_empty;
            DRIVE: state_d = LATCH;
            LATCH: begin
                if (step_q == last_step(cur_q.op)) begin
                    state_d = IDLE;
                    take    = !fifo_empty;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase

        // NOPs and illegal commands are consumed here without touching the bus.
        if (take) begin
            fifo_pop   = 1'b1;
            cur_d      = head_hdr;
            cur_data_d = head_data;
            step_d     = 2'd0;
            if (!cmd_legal(head_hdr)) begin
                err_d = 1'b1;
            end else if (head_hdr.op != OP_NOP) begin
                state_d = DRIVE;
            end
        end
    end

    // Outputs are registered from the current state, so the bus pattern trails the
    // internal state by one cycle.
    always_comb begin
        route      = step_route(cur_q, step_q);
        drv_en_d   = '0;
        ld_en_d    = '0;
        data_out_d = '0;
        if (state_q == DRIVE || state_q == LATCH) begin
            drv_en_d = 4'b0001 << route[3:2];
            if (state_q == LATCH) begin
                ld_en_d = 3'b001 << (route[1:0] - 2'd1);
            end
            if (route[3:2] == DRV_DATA) begin
                data_out_d = cur_data_q;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            cur_q      <= cmd_hdr_t'('0);
            cur_data_q <= '0;
            drv_en_q   <= '0;
            ld_en_q    <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cur_q      <= cur_d;
            cur_data_q <= cur_data_d;
            drv_en_q   <= drv_en_d;
            ld_en_q    <= ld_en_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
        end
    end

    assign drv_en   = drv_en_q;
    assign ld_en    = ld_en_q;
    assign data_out = data_out_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE) || (|fifo_count) || (|drv_en_q);

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: accepted commands are expanded into expected bus
// steps and register contents; a negedge monitor checks every LATCH cycle and err pulse.
module tb_bus_xfer_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          Clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0, cmd_src = '0, cmd_dst = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] data_out;
    logic [3:0]    drv_en;
    logic [2:0]    ld_en;
    logic          busy, err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit            is_err;
        logic [3:0]    drv;
        logic [2:0]    ld;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           exp_q[$];
    logic [DW-1:0] ref_r [4];
    logic [DW-1:0] bus_r [4];
    logic [3:0]    prev_drv = '0;

    bus_xfer_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .Clock     (Clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_data  (cmd_data),
        .data_out  (data_out),
        .drv_en    (drv_en),
        .ld_en     (ld_en),
        .busy      (busy),
        .err       (err)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_step(input int s, input int d, input logic [DW-1:0] data);
        ev_t e;
        e.is_err = 1'b0;
        e.drv    = 4'(1 << s);
        e.ld     = 3'(1 << (d - 1));
        e.data   = data;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.drv    = '0;
        e.ld     = '0;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    // Reference: each command's effect on R1..R3 and its list of bus steps.
    task automatic model_accept(input logic [1:0] op, input logic [1:0] src,
                                input logic [1:0] dst, input logic [DW-1:0] data);
        int a, b, s;
        logic [DW-1:0] t;
        a = int'(src);
        b = int'(dst);
        s = 6 - a - b;
        case (op)
            2'd1: begin
                if (b == 0) push_err();
                else begin
                    push_step(0, b, data);
                    ref_r[b] = data;
                end
            end
            2'd2: begin
                if (a == 0 || b == 0 || a == b) push_err();
                else begin
                    push_step(a, b, '0);
                    ref_r[b] = ref_r[a];
                end
            end
            2'd3: begin
                if (a == 0 || b == 0 || a == b) push_err();
                else begin
                    push_step(a, s, '0);
                    push_step(b, a, '0);
                    push_step(s, b, '0);
                    t        = ref_r[a];
                    ref_r[s] = t;
                    ref_r[a] = ref_r[b];
                    ref_r[b] = t;
                end
            end
            default: ;
        endcase
    endtask

    task automatic monitor();
        ev_t e;
        logic [DW-1:0] v;
        if (reset !== 1'b1) begin
            prev_drv = '0;
            return;
        end
        chk("drv_onehot", 32'($countones(drv_en) <= 1), 1);
        if (!drv_en[0]) chk("data_out_idle_zero", data_out, 0);
        if (ld_en != 0) begin
            chk("step_queued", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("step_kind", e.is_err, 0);
                chk("drv_en_latch", drv_en, e.drv);
                chk("drv_en_drive", prev_drv, e.drv);
                chk("ld_en", ld_en, e.ld);
                chk("data_out", data_out, e.data);
            end
            v = '0;
            if (drv_en[0]) v = data_out;
            for (int i = 1; i < 4; i++) if (drv_en[i]) v = bus_r[i];
            for (int i = 0; i < 3; i++) if (ld_en[i]) bus_r[i+1] = v;
        end
        if (err) begin
            chk("err_queued", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("err_kind", e.is_err, 1);
            end
        end
        prev_drv = drv_en;
    endtask

    always @(negedge Clock) monitor();

    // Called at a negedge; leaves cmd_valid high so a following send is back-to-back.
    task automatic send(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                        input logic [DW-1:0] data, output bit stalled);
        int n;
        n         = 0;
        stalled   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && n < 200) begin
            stalled = 1'b1;
            @(negedge Clock);
            n++;
        end
        chk("accept_in_time", n < 200, 1);
        if (n < 200) model_accept(op, src, dst, data);
        @(negedge Clock);
    endtask

    task automatic stop();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        stop();
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        chk(name, n < 1000, 1);
        repeat (2) @(negedge Clock);
    endtask

    task automatic check_regs(input string name);
        for (int i = 1; i < 4; i++) chk(name, bus_r[i], ref_r[i]);
    endtask

    task automatic rand_legal(output logic [1:0] op, output logic [1:0] src, output logic [1:0] dst);
        if ($urandom_range(0, 1) == 0) begin
            op  = 2'd1;
            src = 2'd0;
            dst = 2'($urandom_range(1, 3));
        end else begin
            op  = 2'd2;
            src = 2'($urandom_range(1, 3));
            dst = 2'((int'(src) % 3) + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit st;
        bit stall_v [6];
        logic [1:0] op, src, dst;
        logic [DW-1:0] pre [4];
        int k;

        for (int i = 0; i < 4; i++) begin
            ref_r[i] = '0;
            bus_r[i] = '0;
        end

        // Reset values and quiet idle.
        @(negedge Clock);
        chk("rst_drv_en", drv_en, 0);
        chk("rst_ld_en", ld_en, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge Clock);
        reset = 1'b1;
        repeat (10) begin
            @(negedge Clock);
            chk("idle_drv_en", drv_en, 0);
            chk("idle_ld_en", ld_en, 0);
            chk("idle_busy", busy, 0);
            chk("idle_cmd_ready", cmd_ready, 1);
        end

        // Three back-to-back loads: latency and gapless data-driver run.
        fork
            begin : load_watch
                int w;
                w = 0;
                while (drv_en === 4'b0000 && w < 20) begin
                    @(negedge Clock);
                    w++;
                end
                chk("load_latency", w, 3);
                for (int j = 0; j < 6; j++) begin
                    chk("load_drv_run", drv_en, 4'b0001);
                    @(negedge Clock);
                end
                chk("load_drv_end", drv_en, 0);
            end
            begin
                send(2'd1, 2'd0, 2'd1, 8'd1, st);
                send(2'd1, 2'd0, 2'd2, 8'd2, st);
                send(2'd1, 2'd0, 2'd3, 8'd3, st);
                stop();
            end
        join
        drain("drain_loads");
        chk("load_r1", bus_r[1], 1);
        chk("load_r2", bus_r[2], 2);
        chk("load_r3", bus_r[3], 3);

        // MOVE R3 -> R1.
        send(2'd2, 2'd3, 2'd1, 8'h00, st);
        drain("drain_move");
        chk("move_r1", bus_r[1], 3);
        check_regs("regs_after_move");

        // SWAP(1,2) from R1=1, R2=2.
        send(2'd1, 2'd0, 2'd1, 8'd1, st);
        drain("drain_reload");
        fork
            begin : swap_watch
                int w, cnt;
                w = 0;
                cnt = 0;
                while (drv_en === 4'b0000 && w < 20) begin
                    @(negedge Clock);
                    w++;
                end
                while (drv_en !== 4'b0000 && cnt < 20) begin
                    cnt++;
                    @(negedge Clock);
                end
                chk("swap_cycles", cnt, 6);
            end
            begin
                send(2'd3, 2'd1, 2'd2, 8'h00, st);
                stop();
            end
        join
        drain("drain_swap");
        chk("swap_r1", bus_r[1], 2);
        chk("swap_r2", bus_r[2], 1);
        chk("swap_r3", bus_r[3], 1);

        // Back-pressure: six commands behind a running SWAP.
        send(2'd3, 2'd1, 2'd3, 8'h00, st);
        for (int j = 0; j < 6; j++) begin
            rand_legal(op, src, dst);
            send(op, src, dst, 8'($urandom), st);
            stall_v[j] = st;
        end
        stop();
        for (int j = 0; j < 4; j++) chk("bp_no_stall", stall_v[j], 0);
        chk("bp_stall_when_full", stall_v[4], 1);
        drain("drain_backpressure");
        check_regs("regs_after_backpressure");

        // Illegal MOVE R2 -> R2.
        fork
            begin : err_watch
                int errc, actc;
                errc = 0;
                actc = 0;
                repeat (8) begin
                    @(negedge Clock);
                    if (err === 1'b1) errc++;
                    if (drv_en !== 4'b0000 || ld_en !== 3'b000) actc++;
                end
                chk("illegal_err_cycles", errc, 1);
                chk("illegal_bus_quiet", actc, 0);
            end
            begin
                send(2'd2, 2'd2, 2'd2, 8'h00, st);
                stop();
            end
        join
        drain("drain_illegal");

        // Random mix, including NOPs and illegal encodings.
        for (int j = 0; j < 80; j++) begin
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 8'($urandom), st);
            if ($urandom_range(0, 1) == 1) begin
                stop();
                repeat ($urandom_range(1, 3)) @(negedge Clock);
            end
        end
        drain("drain_random");
        check_regs("regs_after_random");

        // Reset during the second SWAP step.
        send(2'd1, 2'd0, 2'd1, 8'h11, st);
        send(2'd1, 2'd0, 2'd2, 8'h22, st);
        send(2'd1, 2'd0, 2'd3, 8'h33, st);
        drain("drain_preset");
        for (int i = 0; i < 4; i++) pre[i] = ref_r[i];
        send(2'd3, 2'd1, 2'd2, 8'h00, st);
        stop();
        k = 0;
        while (ld_en === 3'b000 && k < 20) begin
            @(negedge Clock);
            k++;
        end
        chk("swap_step0_seen", k < 20, 1);
        @(negedge Clock);
        chk("swap_step1_drive", drv_en, 4'b0100);
        reset = 1'b0;
        @(negedge Clock);
        exp_q.delete();
        chk("midrst_drv_en", drv_en, 0);
        chk("midrst_ld_en", ld_en, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_err", err, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_r1", bus_r[1], pre[1]);
        chk("midrst_r2", bus_r[2], pre[2]);
        chk("midrst_r3", bus_r[3], pre[1]);
        ref_r[1] = pre[1];
        ref_r[2] = pre[2];
        ref_r[3] = pre[1];
        @(negedge Clock);
        reset = 1'b1;
        @(negedge Clock);
        chk("postrst_busy", busy, 0);
        chk("postrst_cmd_ready", cmd_ready, 1);
        send(2'd1, 2'd0, 2'd2, 8'h5A, st);
        drain("drain_postrst");
        chk("postrst_load_r2", bus_r[2], 8'h5A);
        check_regs("regs_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
